// File: rtl/multdiv_sequencer.sv
// Issue/stall/writeback sequencer for the iterative multiplier/divider in the X stage.
// Launches one op, holds the front of the pipe until a result or timeout, then retires it in one WB cycle.
module multdiv_sequencer #(
    parameter int DATA_W      = 32,
    parameter int RD_W        = 5,
    parameter int TIMEOUT     = 64,
    parameter int RSTATUS_REG = 30,
    parameter int MULT_EXC    = 4,
    parameter int DIV_EXC     = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_mult,
    input  logic              issue_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [RD_W-1:0]   rd,
    input  logic              kill,
    output logic              md_start_mult,
    output logic              md_start_div,
    output logic [DATA_W-1:0] md_op_a,
    output logic [DATA_W-1:0] md_op_b,
    input  logic              md_result_rdy,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    output logic              stall,
    output logic              busy,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [RD_W-1:0]   RSTAT_IDX = RD_W'(RSTATUS_REG);
    localparam logic [DATA_W-1:0] MULT_CODE = DATA_W'(MULT_EXC);
    localparam logic [DATA_W-1:0] DIV_CODE  = DATA_W'(DIV_EXC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_WB
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                is_div_reg;
    logic [RD_W-1:0]     rd_reg;
    logic                start_mult_reg;
    logic                start_div_reg;
    logic [DATA_W-1:0]   op_a_reg;
    logic [DATA_W-1:0]   op_b_reg;
    logic                wb_valid_reg;
    logic [RD_W-1:0]     wb_rd_reg;
    logic [DATA_W-1:0]   wb_data_reg;

    logic accept;
    logic [DATA_W-1:0] exc_code;

    assign accept   = (state_reg == S_IDLE) & (issue_mult | issue_div) & ~kill;
    assign exc_code = is_div_reg ? DIV_CODE : MULT_CODE;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            is_div_reg     <= 1'b0;
            rd_reg         <= '0;
            start_mult_reg <= 1'b0;
            start_div_reg  <= 1'b0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            wb_valid_reg   <= 1'b0;
            wb_rd_reg      <= '0;
            wb_data_reg    <= '0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            start_mult_reg <= 1'b0;
            start_div_reg  <= 1'b0;
            wb_valid_reg   <= 1'b0;
            wb_rd_reg      <= '0;
            wb_data_reg    <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_a_reg       <= op_a;
                        op_b_reg       <= op_b;
                        rd_reg         <= rd;
                        is_div_reg     <= ~issue_mult;
                        start_mult_reg <= issue_mult;
                        start_div_reg  <= ~issue_mult;
                        state_reg      <= S_START;
                    end
                end
                S_START: begin
                    count_reg <= '0;
                    state_reg <= kill ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    count_reg <= count_reg + 1'b1;
                    if (kill) begin
                        state_reg <= S_IDLE;
                    end else if (md_result_rdy) begin
                        state_reg <= S_WB;
                        if (md_exception) begin
                            wb_valid_reg <= 1'b1;
                            wb_rd_reg    <= RSTAT_IDX;
                            wb_data_reg  <= exc_code;
                        end else begin
                            // Writes to r0 are architecturally dropped.
                            wb_valid_reg <= (rd_reg != '0);
                            wb_rd_reg    <= rd_reg;
                            wb_data_reg  <= md_result;
                        end
                    end else if (count_reg == CNT_LAST) begin
                        state_reg    <= S_WB;
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= RSTAT_IDX;
                        wb_data_reg  <= exc_code;
                    end
                end
                S_WB: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign md_start_mult = start_mult_reg;
    assign md_start_div  = start_div_reg;
    assign md_op_a       = op_a_reg;
    assign md_op_b       = op_b_reg;
    assign busy          = (state_reg != S_IDLE);

    // Gated by reset_n so a held issue cannot raise stall while the block is in reset.
    assign stall = reset_n & (accept | (state_reg == S_START) | (state_reg == S_WAIT));

    // A flush arriving in the WB cycle still cancels the retiring write.
    assign wb_valid = wb_valid_reg & ~kill;
    assign wb_rd    = wb_valid ? wb_rd_reg : '0;
    assign wb_data  = wb_valid ? wb_data_reg : '0;

endmodule
